four_bank_mem: RTL and testbench

Banked main-memory model that sits directly downstream of the direct-mapped cache controller. It consumes the controller's mem_rd, mem_wr, mem_addr and mem_din, and returns mem_dout.
- Four word-interleaved banks.
- Fixed two-cycle read latency, matching the controller's fetch pipeline (F_C0 issues, F_C2 consumes).
- Per-bank busy window, so back-to-back requests to one bank stall while line fills across banks stream at one per cycle.

---
 rtl/four_bank_mem_pkg.sv | 26 ++
 rtl/mem_bank.sv | 38 +++
 rtl/four_bank_mem.sv | 64 ++++++
 tb/tb_four_bank_mem.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/four_bank_mem_pkg.sv
// Shared constants and types for the four-bank word-interleaved memory model.
package four_bank_mem_pkg;
   localparam int ADDR_W      = 16;
   localparam int DATA_W      = 16;
   localparam int NUM_BANKS   = 4;
   localparam int BANK_IDX_W  = 2;
   localparam int ROW_W       = 13;
   localparam int BANK_CYCLES = 4;
   localparam int RD_LAT      = 2;
   localparam int BANK_LSB    = 1;
   localparam int ROW_LSB     = 3;
   localparam int CNT_W       = $clog2(BANK_CYCLES);

   typedef logic [BANK_IDX_W-1:0] bank_idx_t;
   typedef logic [ROW_W-1:0]      row_t;
   typedef logic [DATA_W-1:0]     word_t;
   typedef logic [CNT_W-1:0]      cnt_t;

   function automatic bank_idx_t bank_of(input logic [ADDR_W-1:0] a);
      return a[BANK_LSB +: BANK_IDX_W];
   endfunction

   function automatic row_t row_of(input logic [ADDR_W-1:0] a);
      return a[ROW_LSB +: ROW_W];
   endfunction
endpackage

// File: rtl/mem_bank.sv
// One memory bank: row array with synchronous write, asynchronous read and
// an occupancy counter that blocks new accesses for BANK_CYCLES cycles.
module mem_bank
   import four_bank_mem_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  sel_i,
   input  logic  wr_i,
   input  row_t  row_i,
   input  word_t din_i,
   output word_t rd_data_o,
   output logic  busy_o
);
   cnt_t  cnt_q, cnt_d;
   logic  acc;
   word_t mem_q [0:(1<<ROW_W)-1];

   assign busy_o    = (cnt_q != '0);
   assign acc       = sel_i & ~busy_o;
   assign rd_data_o = mem_q[row_i];

   always_comb begin
      cnt_d = cnt_q;
      if (acc)         cnt_d = cnt_t'(BANK_CYCLES - 1);
      else if (busy_o) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (acc && wr_i) mem_q[row_i] <= din_i;
   end
endmodule

// File: rtl/four_bank_mem.sv
// Banked main memory behind the cache controller: address decode, error and
// stall generation, and the fixed-latency read-data pipeline.
module four_bank_mem
   import four_bank_mem_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Rd,
   input  logic                 Wr,
   input  logic [ADDR_W-1:0]    Addr,
   input  logic [DATA_W-1:0]    DataIn,
   output logic [DATA_W-1:0]    DataOut,
   output logic                 Stall,
   output logic [NUM_BANKS-1:0] Busy,
   output logic                 Err
);
   bank_idx_t                            bank;
   row_t                                 row;
   logic                                 req_ok;
   logic                                 rd_acc;
   logic [NUM_BANKS-1:0]                 sel;
   logic [NUM_BANKS-1:0][DATA_W-1:0]     rd_data;
   logic [RD_LAT:1]                      vld_pipe_q;
   logic [RD_LAT:1][DATA_W-1:0]          dat_pipe_q;

   assign bank   = bank_of(Addr);
   assign row    = row_of(Addr);
   // Outputs are forced quiet while reset is held.
   assign req_ok = rst & (Rd ^ Wr) & ~Addr[0];
   assign Err    = rst & ((Rd & Wr) | ((Rd | Wr) & Addr[0]));
   assign Stall  = req_ok & Busy[bank];
   assign rd_acc = req_ok & Rd & ~Busy[bank];

   for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      assign sel[i] = req_ok && (bank == bank_idx_t'(i));
      mem_bank u_bank (
         .clk       (clk),
         .rst       (rst),
         .sel_i     (sel[i]),
         .wr_i      (Wr),
         .row_i     (row),
         .din_i     (DataIn),
         .rd_data_o (rd_data[i]),
         .busy_o    (Busy[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe_q <= '0;
         dat_pipe_q <= '0;
      end else begin
         vld_pipe_q[1] <= rd_acc;
         dat_pipe_q[1] <= rd_data[bank];
         for (int s = 2; s <= RD_LAT; s++) begin
            vld_pipe_q[s] <= vld_pipe_q[s-1];
            dat_pipe_q[s] <= dat_pipe_q[s-1];
         end
      end
   end

   // Zero unless a read completes this cycle; never holds a stale word.
   assign DataOut = vld_pipe_q[RD_LAT] ? dat_pipe_q[RD_LAT] : '0;
endmodule

// File: tb/tb_four_bank_mem.sv
// Directed, table-driven check of four_bank_mem plus a mid-read reset sequence.
module tb_four_bank_mem;
   logic        clk = 1'b0;
   logic        rst;
   logic        Rd, Wr;
   logic [15:0] Addr, DataIn, DataOut;
   logic        Stall, Err;
   logic [3:0]  Busy;

   int total = 0;
   int bad   = 0;

   four_bank_mem dut (
      .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
      .DataOut(DataOut), .Stall(Stall), .Busy(Busy), .Err(Err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd, wr;
      logic [15:0] addr, din;
      logic [3:0]  busy;
      logic        stall, err;
      logic [15:0] dout;
   } vec_t;

   vec_t vecs[$];

   function automatic void v(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] din, input logic [3:0] busy,
                             input logic stall, input logic err, input logic [15:0] dout);
      vec_t t;
      t.rd = rd; t.wr = wr; t.addr = addr; t.din = din;
      t.busy = busy; t.stall = stall; t.err = err; t.dout = dout;
      vecs.push_back(t);
   endfunction

   function automatic void idle(input logic [3:0] busy, input logic [15:0] dout);
      v(1'b0, 1'b0, 16'h0, 16'h0, busy, 1'b0, 1'b0, dout);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step%0d got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   initial begin
      // line fill writes, one per bank
      v(0,1,16'h0040,16'h1111, 4'b0000,0,0,16'h0);
      v(0,1,16'h0042,16'h2222, 4'b0001,0,0,16'h0);
      v(0,1,16'h0044,16'h3333, 4'b0011,0,0,16'h0);
      v(0,1,16'h0046,16'h4444, 4'b0111,0,0,16'h0);
      idle(4'b1110, 16'h0);
      idle(4'b1100, 16'h0);
      idle(4'b1000, 16'h0);
      // line fill reads streaming across banks
      v(1,0,16'h0040,16'h0, 4'b0000,0,0,16'h0);
      v(1,0,16'h0042,16'h0, 4'b0001,0,0,16'h0);
      v(1,0,16'h0044,16'h0, 4'b0011,0,0,16'h1111);
      v(1,0,16'h0046,16'h0, 4'b0111,0,0,16'h2222);
      idle(4'b1110, 16'h3333);
      idle(4'b1100, 16'h4444);
      idle(4'b1000, 16'h0);
      // bank conflict
      v(0,1,16'h0008,16'hBEEF, 4'b0000,0,0,16'h0);
      v(1,0,16'h0008,16'h0, 4'b0001,1,0,16'h0);
      v(1,0,16'h0008,16'h0, 4'b0001,1,0,16'h0);
      v(1,0,16'h0008,16'h0, 4'b0001,1,0,16'h0);
      v(1,0,16'h0008,16'h0, 4'b0000,0,0,16'h0);
      idle(4'b0001, 16'h0);
      idle(4'b0001, 16'hBEEF);
      idle(4'b0001, 16'h0);
      // errors
      v(0,1,16'h0012,16'h1234, 4'b0000,0,0,16'h0);
      v(0,1,16'h0010,16'h7777, 4'b0010,0,0,16'h0);
      v(1,1,16'h0010,16'h9999, 4'b0011,0,1,16'h0);
      v(0,1,16'h0013,16'hAAAA, 4'b0011,0,1,16'h0);
      idle(4'b0001, 16'h0);
      v(1,0,16'h0012,16'h0, 4'b0000,0,0,16'h0);
      v(1,0,16'h0010,16'h0, 4'b0010,0,0,16'h0);
      idle(4'b0011, 16'h1234);
      idle(4'b0011, 16'h7777);
      idle(4'b0001, 16'h0);
      // read vs write ordering
      v(0,1,16'h0020,16'hCAFE, 4'b0000,0,0,16'h0);
      idle(4'b0001, 16'h0);
      idle(4'b0001, 16'h0);
      idle(4'b0001, 16'h0);
      v(1,0,16'h0020,16'h0, 4'b0000,0,0,16'h0);
      v(0,1,16'h0022,16'h5555, 4'b0001,0,0,16'h0);
      idle(4'b0011, 16'hCAFE);
      idle(4'b0011, 16'h0);
      idle(4'b0010, 16'h0);
      v(1,0,16'h0022,16'h0, 4'b0000,0,0,16'h0);
      idle(4'b0010, 16'h0);
      idle(4'b0010, 16'h5555);
      // writeback then refill on bank 0
      v(0,1,16'h0200,16'h0F0F, 4'b0010,0,0,16'h0);
      idle(4'b0001, 16'h0);
      idle(4'b0001, 16'h0);
      idle(4'b0001, 16'h0);
      v(0,1,16'h0100,16'hABCD, 4'b0000,0,0,16'h0);
      idle(4'b0001, 16'h0);
      idle(4'b0001, 16'h0);
      idle(4'b0001, 16'h0);
      v(1,0,16'h0200,16'h0, 4'b0000,0,0,16'h0);
      idle(4'b0001, 16'h0);
      idle(4'b0001, 16'h0F0F);
      idle(4'b0001, 16'h0);
      v(1,0,16'h0100,16'h0, 4'b0000,0,0,16'h0);
      idle(4'b0001, 16'h0);
      idle(4'b0001, 16'hABCD);
      idle(4'b0001, 16'h0);

      // reset state, with an illegal request present to show gating
      rst = 1'b0; Rd = 1'b1; Wr = 1'b1; Addr = 16'h0010; DataIn = 16'h0;
      #1;
      chk("rst_busy",  0, {12'h0, Busy}, 16'h0);
      chk("rst_dout",  0, DataOut, 16'h0);
      chk("rst_err",   0, {15'h0, Err}, 16'h0);
      chk("rst_stall", 0, {15'h0, Stall}, 16'h0);
      Rd = 1'b0; Wr = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         Rd = vecs[i].rd; Wr = vecs[i].wr; Addr = vecs[i].addr; DataIn = vecs[i].din;
         @(negedge clk);
         chk("busy",  i, {12'h0, Busy}, {12'h0, vecs[i].busy});
         chk("stall", i, {15'h0, Stall}, {15'h0, vecs[i].stall});
         chk("err",   i, {15'h0, Err}, {15'h0, vecs[i].err});
         chk("dout",  i, DataOut, vecs[i].dout);
         @(posedge clk); #1;
      end

      // reset with a read in flight
      Rd = 1'b1; Wr = 1'b0; Addr = 16'h0040;
      @(posedge clk); #2;
      Wr = 1'b1; rst = 1'b0;
      #1;
      chk("midrst_busy",  0, {12'h0, Busy}, 16'h0);
      chk("midrst_dout",  0, DataOut, 16'h0);
      chk("midrst_err",   0, {15'h0, Err}, 16'h0);
      chk("midrst_stall", 0, {15'h0, Stall}, 16'h0);
      Rd = 1'b0; Wr = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("postrst_dout", k, DataOut, 16'h0);
      end
      // array survives reset
      @(posedge clk); #1;
      Rd = 1'b1; Addr = 16'h0040;
      @(posedge clk); #1;
      Rd = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("keep_dout", 0, DataOut, 16'h1111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
